// File: rtl/crc_stream_engine_if.sv
// Stream input / result output bundle of crc_stream_engine.
// The m_match result bit is present only when CRC_CHECK_EN is defined.
interface crc_stream_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 32
) ();
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;
  logic [DATA_WIDTH/8-1:0] s_strb;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [CRC_WIDTH-1:0]    m_crc;
  logic [CNT_WIDTH-1:0]    m_bytes;
  logic                    m_err;
`ifdef CRC_CHECK_EN
  logic                    m_match;

  modport master (output s_valid, s_data, s_strb, s_last, m_ready,
                  input  s_ready, m_valid, m_crc, m_bytes, m_err, m_match);
  modport slave  (input  s_valid, s_data, s_strb, s_last, m_ready,
                  output s_ready, m_valid, m_crc, m_bytes, m_err, m_match);
`else
  modport master (output s_valid, s_data, s_strb, s_last, m_ready,
                  input  s_ready, m_valid, m_crc, m_bytes, m_err);
  modport slave  (input  s_valid, s_data, s_strb, s_last, m_ready,
                  output s_ready, m_valid, m_crc, m_bytes, m_err);
`endif
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: per-frame programmable poly/init/xorout/reflection, byte strobes,
// registered result with byte count and framing error. CRC_CHECK_EN adds cfg_expect/m_match.
module crc_stream_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 crc_clk,
  input  logic                 crc_rst_n,
  input  logic [CRC_WIDTH-1:0] cfg_poly,
  input  logic [CRC_WIDTH-1:0] cfg_init,
  input  logic [CRC_WIDTH-1:0] cfg_xorout,
  input  logic                 cfg_refin,
  input  logic                 cfg_refout,
`ifdef CRC_CHECK_EN
  input  logic [CRC_WIDTH-1:0] cfg_expect,
`endif
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  crc_stream_engine_if.slave   bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_WIDTH + POP_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_d;
  logic [CRC_WIDTH-1:0] sh_poly, sh_xorout;
  logic                 sh_refin, sh_refout;
  logic [CRC_WIDTH-1:0] crc_q, crc_next, crc_final;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_next;
  logic [SUM_W-1:0]     cnt_sum;
  logic [POP_W-1:0]     pop;
  logic                 err_q, err_next;
  logic                 load, xfer, fin;
`ifdef CRC_CHECK_EN
  logic [CRC_WIDTH-1:0] sh_expect;
`endif

  // One byte through the shift register; lsb_first selects the bit order within the byte.
  function automatic logic [CRC_WIDTH-1:0] fold_byte(input logic [CRC_WIDTH-1:0] crc,
                                                     input logic [7:0] b,
                                                     input logic lsb_first,
                                                     input logic [CRC_WIDTH-1:0] poly);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ (lsb_first ? b[7-i] : b[i]);
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    return c;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] reflect(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state;
    load    = 1'b0;
    xfer    = 1'b0;
    fin     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
        RUN: if (bus.s_valid && bus.s_ready) begin
          xfer = 1'b1;
          if (bus.s_last) begin
            fin     = 1'b1;
            state_d = DONE;
          end
        end
        DONE: if (bus.m_valid && bus.m_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Enabled lanes fold in ascending order, so lane 0 is the oldest byte of the beat.
  always_comb begin
    crc_next = crc_q;
    pop      = '0;
    for (int l = 0; l < LANES; l++) begin
      if (bus.s_strb[l]) begin
        crc_next = fold_byte(crc_next, bus.s_data[8*l +: 8], sh_refin, sh_poly);
        pop      = pop + POP_W'(1);
      end
    end
  end

  assign cnt_sum   = SUM_W'(cnt_q) + SUM_W'(pop);
  assign cnt_next  = (cnt_sum[SUM_W-1:CNT_WIDTH] != '0) ? '1 : cnt_sum[CNT_WIDTH-1:0];
  // A contiguous strobe 0..01..1 has no carry-chain overlap with itself plus one.
  assign err_next  = err_q | ((bus.s_strb & (bus.s_strb + LANES'(1))) != '0);
  assign crc_final = (sh_refout ? reflect(crc_next) : crc_next) ^ sh_xorout;

  always_ff @(posedge crc_clk or negedge crc_rst_n) begin
    if (!crc_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge crc_clk or negedge crc_rst_n) begin
    if (!crc_rst_n) begin
      busy        <= 1'b0;
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_crc   <= '0;
      bus.m_bytes <= '0;
      bus.m_err   <= 1'b0;
      sh_poly     <= '0;
      sh_xorout   <= '0;
      sh_refin    <= 1'b0;
      sh_refout   <= 1'b0;
      crc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
`ifdef CRC_CHECK_EN
      sh_expect   <= '0;
      bus.m_match <= 1'b0;
`endif
    end else begin
      busy        <= (state_d != IDLE);
      bus.s_ready <= (state_d == RUN);
      bus.m_valid <= (state_d == DONE);
      if (load) begin
        sh_poly   <= cfg_poly;
        sh_xorout <= cfg_xorout;
        sh_refin  <= cfg_refin;
        sh_refout <= cfg_refout;
        crc_q     <= cfg_init;
        cnt_q     <= '0;
        err_q     <= 1'b0;
`ifdef CRC_CHECK_EN
        sh_expect <= cfg_expect;
`endif
      end
      if (xfer) begin
        crc_q <= crc_next;
        cnt_q <= cnt_next;
        err_q <= err_next;
      end
      if (fin) begin
        bus.m_crc   <= crc_final;
        bus.m_bytes <= cnt_next;
        bus.m_err   <= err_next;
`ifdef CRC_CHECK_EN
        bus.m_match <= (crc_final == sh_expect);
`endif
      end
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomized self-checking bench for crc_stream_engine: byte-queue reference model,
// one result compare process, directed CRC-32 / CRC-16 literal frames.
module tb_crc_stream_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] data; logic [3:0] strb; } beat_t;
  typedef struct { logic [31:0] crc; logic [31:0] bytes; logic err; logic match; } exp_t;

  beat_t      beats[$];
  logic [7:0] msg[$];
  logic [7:0] src[$];
  exp_t       expq[$];

  // 32-bit engine
  logic [31:0] poly32 = '0, init32 = '0, xor32 = '0, exp32 = '0;
  logic        refin32 = 0, refout32 = 0, start32 = 0, abort32 = 0, busy32;
  crc_stream_engine_if #(.DATA_WIDTH(32), .CRC_WIDTH(32), .CNT_WIDTH(32)) b32 ();
  crc_stream_engine #(.DATA_WIDTH(32), .CRC_WIDTH(32), .CNT_WIDTH(32)) u32 (
    .crc_clk(clk), .crc_rst_n(rst_n), .cfg_poly(poly32), .cfg_init(init32),
    .cfg_xorout(xor32), .cfg_refin(refin32), .cfg_refout(refout32),
`ifdef CRC_CHECK_EN
    .cfg_expect(exp32),
`endif
    .start(start32), .abort(abort32), .busy(busy32), .bus(b32.slave));

  // 16-bit CRC, 16-bit data, 4-bit saturating counter
  logic [15:0] poly16 = '0, init16 = '0, xor16 = '0;
  logic        refin16 = 0, refout16 = 0, start16 = 0, abort16 = 0, busy16;
`ifdef CRC_CHECK_EN
  logic [15:0] exp16 = '0;
`endif
  crc_stream_engine_if #(.DATA_WIDTH(16), .CRC_WIDTH(16), .CNT_WIDTH(4)) b16 ();
  crc_stream_engine #(.DATA_WIDTH(16), .CRC_WIDTH(16), .CNT_WIDTH(4)) u16 (
    .crc_clk(clk), .crc_rst_n(rst_n), .cfg_poly(poly16), .cfg_init(init16),
    .cfg_xorout(xor16), .cfg_refin(refin16), .cfg_refout(refout16),
`ifdef CRC_CHECK_EN
    .cfg_expect(exp16),
`endif
    .start(start16), .abort(abort16), .busy(busy16), .bus(b16.slave));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference CRC over msg[] as a flat bit stream, plain integer arithmetic.
  function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly, init, xorout,
                                            input logic refin, refout);
    longint unsigned mask, top, r, o;
    bit fb;
    mask = (64'd1 << w) - 1;
    top  = 64'd1 << (w - 1);
    r    = init & mask;
    foreach (msg[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = ((r & top) != 0) ^ (refin ? msg[k][j] : msg[k][7-j]);
        r  = (r << 1) & mask;
        if (fb) r = r ^ (poly & mask);
      end
    end
    o = r;
    if (refout) begin
      o = 0;
      for (int i = 0; i < w; i++) if (r[i]) o = o | (top >> i);
    end
    return 32'((o ^ xorout) & mask);
  endfunction

  // Byte stream, saturated count and framing error implied by beats[].
  task automatic model_frame(input int cnt_w, output logic [31:0] bytes, output logic err);
    longint unsigned n, cap;
    int p;
    msg.delete();
    n = 0;
    err = 0;
    cap = (64'd1 << cnt_w) - 1;
    foreach (beats[b]) begin
      p = 0;
      for (int l = 0; l < 4; l++) begin
        if (beats[b].strb[l]) begin
          msg.push_back(beats[b].data[8*l +: 8]);
          p++;
        end
      end
      if (beats[b].strb != 4'((1 << p) - 1)) err = 1;
      n += longint'(p);
    end
    bytes = 32'((n > cap) ? cap : n);
  endtask

  task automatic pack(input int lanes);
    beat_t b;
    beats.delete();
    for (int i = 0; i < src.size(); i += lanes) begin
      b.data = '0;
      b.strb = '0;
      for (int l = 0; l < lanes && i + l < src.size(); l++) begin
        b.data[8*l +: 8] = src[i+l];
        b.strb[l] = 1'b1;
      end
      beats.push_back(b);
    end
  endtask

  task automatic load_123456789();
    src.delete();
    for (int c = 8'h31; c <= 8'h39; c++) src.push_back(8'(c));
  endtask

  // Result compare: every cycle m_valid is high the held result must equal the model.
  initial begin
    exp_t cur;
    bit   have_cur;
    have_cur = 0;
    cur = '{crc: '0, bytes: '0, err: 1'b0, match: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 0;
      end else if (b32.m_valid) begin
        if (!have_cur) begin
          check("pending_result", 64'(expq.size() != 0), 1);
          if (expq.size() != 0) cur = expq.pop_front();
          have_cur = 1;
        end
        check("m_crc", b32.m_crc, cur.crc);
        check("m_bytes", b32.m_bytes, cur.bytes);
        check("m_err", b32.m_err, cur.err);
`ifdef CRC_CHECK_EN
        check("m_match", b32.m_match, cur.match);
`endif
        if (b32.m_ready) have_cur = 0;
      end
    end
  end

  // exp_mode: 0 random cfg_expect, 1 expect the right CRC, 2 expect zero.
  task automatic run32(input logic [31:0] poly, init, xo, input logic ri, ro,
                       input int abort_at, input int hold, input bit poke, input int exp_mode);
    exp_t        e;
    logic [31:0] ev, bytes;
    logic        err;
    bit          acc;
    model_frame(32, bytes, err);
    e.crc   = model_crc(32, poly, init, xo, ri, ro);
    e.bytes = bytes;
    e.err   = err;
    ev      = (exp_mode == 1) ? e.crc : (exp_mode == 2) ? 32'h0 : $urandom;
    e.match = (e.crc == ev);
    @(posedge clk); #1;
    poly32 = poly; init32 = init; xor32 = xo; refin32 = ri; refout32 = ro; exp32 = ev;
    start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    poly32 = $urandom; init32 = $urandom; xor32 = $urandom; exp32 = $urandom;
    refin32 = 1'($urandom); refout32 = 1'($urandom);
    @(negedge clk);
    check("busy_after_start", busy32, 1);
    check("ready_after_start", b32.s_ready, 1);
    @(posedge clk); #1;
    if (abort_at < 0) expq.push_back(e);
    for (int k = 0; k < beats.size(); k++) begin
      b32.s_valid = 1; b32.s_data = beats[k].data; b32.s_strb = beats[k].strb;
      if (k == abort_at) begin
        b32.s_last = 1; abort32 = 1;
        @(posedge clk); #1;
        abort32 = 0; b32.s_valid = 0; b32.s_last = 0;
        repeat (3) begin
          @(negedge clk);
          check("abort_busy", busy32, 0);
          check("abort_ready", b32.s_ready, 0);
          check("abort_valid", b32.m_valid, 0);
        end
        @(posedge clk); #1;
        return;
      end
      b32.s_last = (k == beats.size() - 1);
      acc = 0;
      for (int t = 0; t < 16 && !acc; t++) begin
        @(negedge clk); acc = b32.s_ready;
        @(posedge clk); #1;
      end
      check("beat_accept", acc, 1);
      b32.s_valid = 0; b32.s_last = 0;
      if (k != beats.size() - 1 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    check("m_valid_latency", b32.m_valid, 1);
    @(posedge clk); #1;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin start32 = 1; b32.s_valid = 1; b32.s_last = 1; end
      @(negedge clk);
      check("ready_in_done", b32.s_ready, 0);
      check("busy_in_done", busy32, 1);
      @(posedge clk); #1;
    end
    start32 = 0; b32.s_valid = 0; b32.s_last = 0; b32.m_ready = 1;
    @(posedge clk); #1;
    b32.m_ready = 0;
    @(negedge clk);
    check("idle_busy", busy32, 0);
    check("idle_valid", b32.m_valid, 0);
    if (poke) begin
      @(negedge clk);
      check("start_ignored", b32.s_ready, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic run16(output logic [15:0] crc_got, output logic [31:0] bytes_want);
    logic [31:0] crc_want;
    logic        err;
    bit          acc;
    model_frame(4, bytes_want, err);
    crc_want = model_crc(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    poly16 = 16'h1021; init16 = 16'hFFFF; xor16 = 16'h0; refin16 = 0; refout16 = 0; start16 = 1;
    @(posedge clk); #1;
    start16 = 0; poly16 = 16'($urandom); init16 = 16'($urandom);
    for (int k = 0; k < beats.size(); k++) begin
      b16.s_valid = 1; b16.s_data = beats[k].data[15:0]; b16.s_strb = beats[k].strb[1:0];
      b16.s_last = (k == beats.size() - 1);
      acc = 0;
      for (int t = 0; t < 16 && !acc; t++) begin
        @(negedge clk); acc = b16.s_ready;
        @(posedge clk); #1;
      end
      check("beat16_accept", acc, 1);
    end
    b16.s_valid = 0; b16.s_last = 0;
    @(negedge clk);
    check("m16_valid", b16.m_valid, 1);
    check("m16_crc", b16.m_crc, crc_want);
    check("m16_bytes", b16.m_bytes, bytes_want);
    check("m16_err", b16.m_err, err);
    crc_got = b16.m_crc;
    @(posedge clk); #1;
    b16.m_ready = 1;
    @(posedge clk); #1;
    b16.m_ready = 0;
    @(negedge clk);
    check("m16_idle_busy", busy16, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] bytes, nb32;
    logic [15:0] crc16;
    logic        err;
    beat_t       b;
    int          nb, ab;
    b32.s_valid = 0; b32.s_data = '0; b32.s_strb = '0; b32.s_last = 0; b32.m_ready = 0;
    b16.s_valid = 0; b16.s_data = '0; b16.s_strb = '0; b16.s_last = 0; b16.m_ready = 0;

    #12;
    check("rst_busy", busy32, 0);
    check("rst_ready", b32.s_ready, 0);
    check("rst_valid", b32.m_valid, 0);
    check("rst_crc", b32.m_crc, 0);
    check("rst_bytes", b32.m_bytes, 0);
    check("rst_err", b32.m_err, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // CRC-32 check value; pin the model, then the DUT.
    load_123456789(); pack(4);
    model_frame(32, bytes, err);
    check("model_crc32", model_crc(32, 32'h04C11DB7, '1, '1, 1, 1), 32'hCBF43926);
    run32(32'h04C11DB7, '1, '1, 1, 1, -1, 0, 0, 1);
    check("crc32_literal", b32.m_crc, 32'hCBF43926);
    check("crc32_bytes", b32.m_bytes, 9);
    check("crc32_err", b32.m_err, 0);
`ifdef CRC_CHECK_EN
    check("match_hit", b32.m_match, 1);
    run32(32'h04C11DB7, '1, '1, 1, 1, -1, 0, 0, 2);
    check("match_miss", b32.m_match, 0);
`endif

    // Result held under back-pressure while start and s_valid are pulsed.
    run32(32'h04C11DB7, '1, '1, 1, 1, -1, 5, 1, 0);

    // Null beat mid-frame, then a non-contiguous strobe on a non-last beat.
    beats.delete();
    b = '{32'h34333231, 4'hF}; beats.push_back(b);
    b = '{32'hDEADBEEF, 4'h0}; beats.push_back(b);
    b = '{32'h38373635, 4'h5}; beats.push_back(b);
    b = '{32'h00000039, 4'h1}; beats.push_back(b);
    run32(32'h04C11DB7, '1, '1, 1, 1, -1, 0, 0, 0);
    check("null_err", b32.m_err, 1);
    check("null_bytes", b32.m_bytes, 7);

    // Abort after two beats (on a beat flagged last), then a clean frame.
    load_123456789(); pack(4);
    b = '{32'h11223344, 4'hF}; beats.push_back(b);
    run32(32'h04C11DB7, '1, '1, 1, 1, 2, 0, 0, 0);
    load_123456789(); pack(4);
    run32(32'h04C11DB7, '1, '1, 1, 1, -1, 0, 0, 0);
    check("post_abort_crc", b32.m_crc, 32'hCBF43926);

    // Asynchronous reset in the middle of a frame.
    @(posedge clk); #1;
    start32 = 1;
    @(posedge clk); #1;
    start32 = 0; b32.s_valid = 1; b32.s_data = $urandom; b32.s_strb = 4'hF;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("midrst_busy", busy32, 0);
    check("midrst_ready", b32.s_ready, 0);
    check("midrst_valid", b32.m_valid, 0);
    b32.s_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // CRC-16/CCITT-FALSE, then a frame long enough to saturate the 4-bit counter.
    load_123456789(); pack(2);
    model_frame(4, nb32, err);
    check("model_crc16", model_crc(16, 32'h1021, 32'hFFFF, 0, 0, 0), 32'h29B1);
    run16(crc16, nb32);
    check("crc16_literal", crc16, 16'h29B1);
    check("crc16_bytes", b16.m_bytes, 9);
    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
    pack(2);
    run16(crc16, nb32);
    check("sat_bytes", b16.m_bytes, 15);

    // Randomized frames: config, data, strobes, gaps, aborts, back-pressure.
    for (int f = 0; f < 40; f++) begin
      beats.delete();
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        b.data = $urandom;
        b.strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        beats.push_back(b);
      end
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1;
      run32($urandom | 32'h1, $urandom, $urandom, 1'($urandom), 1'($urandom),
            ab, $urandom_range(0, 3), bit'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    check("results_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
